universal_shift_reg: RTL and testbench

- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with clock enable and eight operating modes (hold, parallel load, shift and rotate in both directions, clear, invert).
- A saturating shift counter and a `drained` flag let it act as a serializer or deserializer.
- Sits behind the standard tt_um_ top-level wrapper: mode and control come from ui_in, data from uio_in, the register drives uo_out.

---
 rtl/usr_pkg.sv | 20 ++
 rtl/tt_um_usr_holmes.sv | 41 ++++
 rtl/usr_next_state.sv | 30 +++
 rtl/universal_shift_reg.sv | 73 +++++++
 tb/tb_universal_shift_reg.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_LOAD   = 3'b001,
        MODE_SHL    = 3'b010,
        MODE_SHR    = 3'b011,
        MODE_ROTL   = 3'b100,
        MODE_ROTR   = 3'b101,
        MODE_CLEAR  = 3'b110,
        MODE_INVERT = 3'b111
    } mode_e;

    // Width of a counter that must reach the value w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/tt_um_usr_holmes.sv
// Tiny Tapeout wrapper: mode/serial bits from ui_in, load data from uio_in, q on uo_out.
module tt_um_usr_holmes (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic       unused_sout_msb;
    logic       unused_sout_lsb;
    logic [3:0] unused_shift_cnt;
    logic       unused_drained;
    logic       unused_ui;

    universal_shift_reg #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) u_usr (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (ui_in[2:0]),
        .d         (uio_in),
        .sin_lsb   (ui_in[3]),
        .sin_msb   (ui_in[4]),
        .q         (uo_out),
        .sout_msb  (unused_sout_msb),
        .sout_lsb  (unused_sout_lsb),
        .shift_cnt (unused_shift_cnt),
        .drained   (unused_drained)
    );

    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ui = &{1'b0, ui_in[7:5]};

endmodule

// File: rtl/usr_next_state.sv
// Combinational next-value logic for the shift register data path.
module usr_next_state
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  mode_e             mode,
    input  logic [WIDTH-1:0]  q,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_lsb,
    input  logic              sin_msb,
    output logic [WIDTH-1:0]  q_next_c
);

    always_comb begin
        q_next_c = q;
        unique case (mode)
            MODE_HOLD:   q_next_c = q;
            MODE_LOAD:   q_next_c = d;
            MODE_SHL:    q_next_c = {q[WIDTH-2:0], sin_lsb};
            MODE_SHR:    q_next_c = {sin_msb, q[WIDTH-1:1]};
            MODE_ROTL:   q_next_c = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR:   q_next_c = {q[0], q[WIDTH-1:1]};
            MODE_CLEAR:  q_next_c = '0;
            MODE_INVERT: q_next_c = ~q;
            default:     q_next_c = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with clock enable and saturating shift counter.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int unsigned    CW          = cnt_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_lsb,
    input  logic              sin_msb,
    output logic [WIDTH-1:0]  q,
    output logic              sout_msb,
    output logic              sout_lsb,
    output logic [CW-1:0]     shift_cnt,
    output logic              drained
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_next_c;
    logic             is_shift_c;
    logic             cnt_clear_c;

    assign mode_sel = mode_e'(mode);

    usr_next_state #(
        .WIDTH (WIDTH)
    ) u_next_state (
        .mode     (mode_sel),
        .q        (q),
        .d        (d),
        .sin_lsb  (sin_lsb),
        .sin_msb  (sin_msb),
        .q_next_c (q_next_c)
    );

    // Classify the sampled mode for the counter.
    always_comb begin
        is_shift_c  = 1'b0;
        cnt_clear_c = 1'b0;
        unique case (mode_sel)
            MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR: is_shift_c  = 1'b1;
            MODE_LOAD, MODE_CLEAR:                    cnt_clear_c = 1'b1;
            default: ;
        endcase
    end

    // Reset beats enable; enable beats mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q         <= RESET_VALUE;
            shift_cnt <= '0;
        end else if (ena) begin
            q <= q_next_c;
            if (cnt_clear_c) begin
                shift_cnt <= '0;
            end else if (is_shift_c && (shift_cnt != CNT_MAX)) begin
                shift_cnt <= shift_cnt + CW'(1);
            end
        end
    end

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];
    assign drained  = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed scenarios plus random traffic against a byte-level model.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_lsb;
    logic       sin_msb;
    logic [7:0] q,  q2;
    logic       sout_msb, sout_lsb, sout_msb2, sout_lsb2;
    logic [3:0] shift_cnt, shift_cnt2;
    logic       drained, drained2;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q;
    int         m_cnt;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .d(d),
        .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q), .sout_msb(sout_msb),
        .sout_lsb(sout_lsb), .shift_cnt(shift_cnt), .drained(drained)
    );

    universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut_rv (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .d(d),
        .sin_lsb(sin_lsb), .sin_msb(sin_msb), .q(q2), .sout_msb(sout_msb2),
        .sout_lsb(sout_lsb2), .shift_cnt(shift_cnt2), .drained(drained2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge: drive inputs, advance the model, compare every output.
    task automatic cycle(input logic r, input logic e, input logic [2:0] m,
                         input logic [7:0] dd, input logic sl, input logic sm);
        rst_n = r; ena = e; mode = m; d = dd; sin_lsb = sl; sin_msb = sm;
        @(posedge clk);
        if (!r) begin
            m_q = 8'h00; m_cnt = 0;
        end else if (e) begin
            case (m)
                3'd1: begin m_q = dd; m_cnt = 0; end
                3'd2: m_q = 8'(m_q << 1) | {7'd0, sl};
                3'd3: m_q = (m_q >> 1) | (sm ? 8'h80 : 8'h00);
                3'd4: m_q = 8'(m_q << 1) | (m_q >> 7);
                3'd5: m_q = (m_q >> 1) | 8'(m_q << 7);
                3'd6: begin m_q = 8'h00; m_cnt = 0; end
                3'd7: m_q = ~m_q;
                default: ;
            endcase
            if (m >= 3'd2 && m <= 3'd5 && m_cnt < 8) m_cnt++;
        end
        #1;
        check("q", 32'(q), 32'(m_q));
        check("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
        check("drained", 32'(drained), 32'(m_cnt == 8));
        check("sout_msb", 32'(sout_msb), 32'(m_q[7]));
        check("sout_lsb", 32'(sout_lsb), 32'(m_q[0]));
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] sbits;
        m_q = 8'h00; m_cnt = 0;
        rst_n = 1'b0; ena = 1'b0; mode = 3'd0; d = 8'h00; sin_lsb = 1'b0; sin_msb = 1'b0;

        // Reset for two edges, then release with HOLD.
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        check("reset_q", 32'(q), 32'h00);
        check("reset_q_rv", 32'(q2), 32'hA5);
        check("reset_cnt_rv", 32'(shift_cnt2), 32'h0);
        cycle(1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        check("hold_q_rv", 32'(q2), 32'hA5);

        // Serializer: bits emerge MSB first on sout_msb.
        pat = 8'hB4;
        cycle(1'b1, 1'b1, 3'd1, pat, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("ser_bit", 32'(sout_msb), 32'(pat[7-i]));
            cycle(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        end
        check("ser_q", 32'(q), 32'h00);
        check("ser_drained", 32'(drained), 32'h1);
        cycle(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        check("ser_sat", 32'(shift_cnt), 32'd8);
        cycle(1'b1, 1'b1, 3'd1, 8'h12, 1'b0, 1'b0);
        check("reload_drained", 32'(drained), 32'h0);

        // Rotate round trip.
        cycle(1'b1, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        check("rotr_q", 32'(q), 32'h30);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        check("rotl_q", 32'(q), 32'h81);
        check("rot_cnt", 32'(shift_cnt), 32'd6);

        // Enable gating.
        cycle(1'b1, 1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [2:0] gm;
            gm = (i % 3 == 0) ? 3'd2 : ((i % 3 == 1) ? 3'd6 : 3'd7);
            cycle(1'b1, 1'b0, gm, 8'hFF, 1'b1, 1'b1);
        end
        check("gate_q", 32'(q), 32'h5A);
        check("gate_cnt", 32'(shift_cnt), 32'h0);
        cycle(1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        check("invert_q", 32'(q), 32'hA5);

        // Reset in the middle of a shift sequence.
        cycle(1'b1, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
        check("shr_q", 32'(q), 32'h0F);
        cycle(1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
        check("midrst_q", 32'(q), 32'h00);
        check("midrst_cnt", 32'(shift_cnt), 32'h0);
        cycle(1'b0, 1'b1, 3'd1, 8'h77, 1'b0, 1'b0);
        check("rst_wins", 32'(q), 32'h00);

        // Deserializer then CLEAR.
        sbits = 8'b1011_1001;
        cycle(1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3'd3, 8'h00, 1'b0, sbits[i]);
        check("deser_q", 32'(q), 32'hB9);
        check("deser_drained", 32'(drained), 32'h1);
        cycle(1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        check("clear_q", 32'(q), 32'h00);
        check("clear_drained", 32'(drained), 32'h0);

        // Random traffic, biased toward shifts so the counter saturates often.
        for (int i = 0; i < 600; i++) begin
            logic       r, e;
            logic [2:0] m;
            r = ($urandom_range(0, 39) != 0);
            e = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(2, 5)) : 3'($urandom_range(0, 7));
            cycle(r, e, m, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
